// File: rtl/pc_stack.sv
// pc_stack: parametrised program counter with a hardware call/return stack.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst          - asynchronous reset, active low
//   en_in        - update enable; when 0 all state holds and stack_err clears
//   pc_ctrl      - operation select (HOLD/INC/BRANCH/SJUMP/LJUMP/CALL/RET/rsvd)
//   offset_addr  - signed branch offset or zero-extended short jump target
//   jump_addr    - long jump / call target
//   pc_out       - current PC (registered)
//   stack_empty  - stack holds 0 entries (registered)
//   stack_full   - stack holds STACK_DEPTH entries (registered)
//   stack_err    - one-cycle pulse after an illegal CALL or RETURN (registered)
module pc_stack #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned OFF_W       = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [2:0]        pc_ctrl,
    input  logic [OFF_W-1:0]  offset_addr,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_BRANCH = 3'b010,
        OP_SJUMP  = 3'b011,
        OP_LJUMP  = 3'b100,
        OP_CALL   = 3'b101,
        OP_RET    = 3'b110,
        OP_RSVD   = 3'b111
    } op_e;

    op_e                op;
    logic [ADDR_W-1:0]  mem [STACK_DEPTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   next_cnt;
    logic [ADDR_W-1:0]  next_pc;
    logic [ADDR_W-1:0]  off_sext;
    logic [ADDR_W-1:0]  off_zext;
    logic [ADDR_W-1:0]  ret_addr;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   top_idx;
    logic               push;
    logic               err_next;

    assign op       = op_e'(pc_ctrl);
    assign off_sext = ADDR_W'($signed(offset_addr));
    assign off_zext = ADDR_W'(offset_addr);
    assign ret_addr = pc_out + ADDR_W'(1);
    // Push writes the slot at the current count; the top entry sits one below.
    assign wr_idx   = PTR_W'(count);
    assign top_idx  = PTR_W'(count - CNT_W'(1));

    always_comb begin
        next_pc  = pc_out;
        next_cnt = count;
        push     = 1'b0;
        err_next = 1'b0;
        if (en_in) begin
            case (op)
                OP_INC:    next_pc = pc_out + ADDR_W'(1);
                OP_BRANCH: next_pc = pc_out + off_sext;
                OP_SJUMP:  next_pc = off_zext;
                OP_LJUMP:  next_pc = jump_addr;
                OP_CALL: begin
                    if (stack_full) begin
                        err_next = 1'b1;
                    end else begin
                        push     = 1'b1;
                        next_pc  = jump_addr;
                        next_cnt = count + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        err_next = 1'b1;
                    end else begin
                        next_pc  = mem[top_idx];
                        next_cnt = count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_out      <= RESET_ADDR;
            count       <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            pc_out      <= next_pc;
            count       <= next_cnt;
            stack_empty <= (next_cnt == '0);
            stack_full  <= (next_cnt == CNT_W'(STACK_DEPTH));
            stack_err   <= err_next;
        end
    end

    // Stack RAM is not reset; its contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= ret_addr;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_in;
    logic [2:0]  pc_ctrl;
    logic [7:0]  offset_addr;
    logic [15:0] jump_addr;
    logic [15:0] pc_out;
    logic        stack_empty, stack_full, stack_err;

    // Second instance exercising the single-entry stack corner case.
    logic        en1;
    logic [2:0]  ctrl1;
    logic [7:0]  off1;
    logic [7:0]  jaddr1;
    logic [7:0]  pc1;
    logic        empty1, full1, err1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    pc_stack #(.ADDR_W(16), .OFF_W(8), .STACK_DEPTH(4), .RESET_ADDR(16'h0010)) u_dut (
        .clk(clk), .rst(rst), .en_in(en_in), .pc_ctrl(pc_ctrl),
        .offset_addr(offset_addr), .jump_addr(jump_addr), .pc_out(pc_out),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    pc_stack #(.ADDR_W(8), .OFF_W(8), .STACK_DEPTH(1), .RESET_ADDR(8'h00)) u_d1 (
        .clk(clk), .rst(rst), .en_in(en1), .pc_ctrl(ctrl1),
        .offset_addr(off1), .jump_addr(jaddr1), .pc_out(pc1),
        .stack_empty(empty1), .stack_full(full1), .stack_err(err1)
    );

    typedef struct {
        string       name;
        logic        en;
        logic [2:0]  ctrl;
        logic [7:0]  off;
        logic [15:0] jaddr;
        logic [15:0] exp_pc;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, BR = 3'b010, SJ = 3'b011,
                           LJ = 3'b100, CALL = 3'b101, RET = 3'b110, RSVD = 3'b111;

    task automatic add(input string nm, input logic en, input logic [2:0] c,
                       input logic [7:0] o, input logic [15:0] j, input logic [15:0] p,
                       input logic e, input logic f, input logic r);
        vec_t v;
        v.name = nm; v.en = en; v.ctrl = c; v.off = o; v.jaddr = j;
        v.exp_pc = p; v.exp_empty = e; v.exp_full = f; v.exp_err = r;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_main(input string nm, input logic [15:0] p,
                              input logic e, input logic f, input logic r);
        check({nm, ".pc"}, 32'(pc_out), 32'(p));
        check({nm, ".empty"}, 32'(stack_empty), 32'(e));
        check({nm, ".full"}, 32'(stack_full), 32'(f));
        check({nm, ".err"}, 32'(stack_err), 32'(r));
    endtask

    task automatic check_d1(input string nm, input logic [7:0] p,
                            input logic e, input logic f, input logic r);
        check({nm, ".pc"}, 32'(pc1), 32'(p));
        check({nm, ".empty"}, 32'(empty1), 32'(e));
        check({nm, ".full"}, 32'(full1), 32'(f));
        check({nm, ".err"}, 32'(err1), 32'(r));
    endtask

    task automatic step(input logic en, input logic [2:0] c, input logic [7:0] o,
                        input logic [15:0] j);
        en_in = en; pc_ctrl = c; offset_addr = o; jump_addr = j;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic en, input logic [2:0] c, input logic [7:0] j);
        en1 = en; ctrl1 = c; off1 = 8'h00; jaddr1 = j;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en_in = 1'b0; pc_ctrl = HOLD; offset_addr = '0; jump_addr = '0;
        en1 = 1'b0; ctrl1 = HOLD; off1 = '0; jaddr1 = '0;

        //   name        en  ctrl  off    jaddr     pc     emp full err
        add("inc1",      1, INC,  8'h00, 16'h0000, 16'h0011, 1, 0, 0);
        add("inc2",      1, INC,  8'h00, 16'h0000, 16'h0012, 1, 0, 0);
        add("inc3",      1, INC,  8'h00, 16'h0000, 16'h0013, 1, 0, 0);
        add("dis1",      0, INC,  8'h00, 16'h0000, 16'h0013, 1, 0, 0);
        add("dis2",      0, LJ,   8'h00, 16'hBEEF, 16'h0013, 1, 0, 0);
        add("sj2",       1, SJ,   8'h02, 16'h0000, 16'h0002, 1, 0, 0);
        add("br_m4",     1, BR,   8'hFC, 16'h0000, 16'hFFFE, 1, 0, 0);
        add("inc_ffff",  1, INC,  8'h00, 16'h0000, 16'hFFFF, 1, 0, 0);
        add("inc_wrap",  1, INC,  8'h00, 16'h0000, 16'h0000, 1, 0, 0);
        add("sj_a5",     1, SJ,   8'hA5, 16'h0000, 16'h00A5, 1, 0, 0);
        add("lj_1234",   1, LJ,   8'h00, 16'h1234, 16'h1234, 1, 0, 0);
        add("rsvd",      1, RSVD, 8'h55, 16'h9999, 16'h1234, 1, 0, 0);
        add("br_p16",    1, BR,   8'h10, 16'h0000, 16'h1244, 1, 0, 0);
        add("lj_0100",   1, LJ,   8'h00, 16'h0100, 16'h0100, 1, 0, 0);
        add("call_200",  1, CALL, 8'h00, 16'h0200, 16'h0200, 0, 0, 0);
        add("call_300",  1, CALL, 8'h00, 16'h0300, 16'h0300, 0, 0, 0);
        add("ret_201",   1, RET,  8'h00, 16'h0000, 16'h0201, 0, 0, 0);
        add("ret_101",   1, RET,  8'h00, 16'h0000, 16'h0101, 1, 0, 0);
        add("ret_under", 1, RET,  8'h00, 16'h0000, 16'h0101, 1, 0, 1);
        add("hold",      1, HOLD, 8'h00, 16'h0000, 16'h0101, 1, 0, 0);
        add("ov_call1",  1, CALL, 8'h00, 16'h1000, 16'h1000, 0, 0, 0);
        add("ov_call2",  1, CALL, 8'h00, 16'h2000, 16'h2000, 0, 0, 0);
        add("ov_call3",  1, CALL, 8'h00, 16'h3000, 16'h3000, 0, 0, 0);
        add("ov_call4",  1, CALL, 8'h00, 16'h4000, 16'h4000, 0, 1, 0);
        add("ov_call5",  1, CALL, 8'h00, 16'h5000, 16'h4000, 0, 1, 1);
        add("ov_dis",    0, CALL, 8'h00, 16'h5000, 16'h4000, 0, 1, 0);
        add("un_ret1",   1, RET,  8'h00, 16'h0000, 16'h3001, 0, 0, 0);
        add("un_ret2",   1, RET,  8'h00, 16'h0000, 16'h2001, 0, 0, 0);
        add("un_ret3",   1, RET,  8'h00, 16'h0000, 16'h1001, 0, 0, 0);
        add("un_ret4",   1, RET,  8'h00, 16'h0000, 16'h0102, 1, 0, 0);
        add("un_ret5",   1, RET,  8'h00, 16'h0000, 16'h0102, 1, 0, 1);
        add("err_clr",   1, INC,  8'h00, 16'h0000, 16'h0103, 1, 0, 0);
        add("lj_ffff",   1, LJ,   8'h00, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        add("call_wrap", 1, CALL, 8'h00, 16'h0050, 16'h0050, 0, 0, 0);
        add("ret_wrap",  1, RET,  8'h00, 16'h0000, 16'h0000, 1, 0, 0);
        add("br_m1",     1, BR,   8'hFF, 16'h0000, 16'hFFFF, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_main("reset", 16'h0010, 1'b1, 1'b0, 1'b0);
        check_d1("reset_d1", 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ctrl, vecs[i].off, vecs[i].jaddr);
            check_main(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_empty,
                       vecs[i].exp_full, vecs[i].exp_err);
        end

        // Reset mid call sequence: takes effect immediately, discards the stack.
        step(1'b1, CALL, 8'h00, 16'h0700);
        step(1'b1, CALL, 8'h00, 16'h0800);
        check_main("mid_call2", 16'h0800, 1'b0, 1'b0, 1'b0);
        en_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_main("async_rst", 16'h0010, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, RET, 8'h00, 16'h0000);
        check_main("ret_after_rst", 16'h0010, 1'b1, 1'b0, 1'b1);
        step(1'b1, INC, 8'h00, 16'h0000);
        check_main("inc_after_rst", 16'h0011, 1'b1, 1'b0, 1'b0);
        en_in = 1'b0;

        // Single-entry stack: one CALL fills it, a second errors, RETURN empties.
        step1(1'b1, CALL, 8'h40);
        check_d1("d1_call", 8'h40, 1'b0, 1'b1, 1'b0);
        step1(1'b1, CALL, 8'h50);
        check_d1("d1_call_full", 8'h40, 1'b0, 1'b1, 1'b1);
        step1(1'b1, RET, 8'h00);
        check_d1("d1_ret", 8'h01, 1'b1, 1'b0, 1'b0);
        step1(1'b1, RET, 8'h00);
        check_d1("d1_ret_empty", 8'h01, 1'b1, 1'b0, 1'b1);
        en1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter for the teaching CPU datapath, successor to the 8-bit-jump PC. It adds configurable address width, PC-relative signed branches, a full-width absolute jump, and a hardware call/return stack of configurable depth with full/empty flags and an error pulse. It sits between the control unit (which drives `pc_ctrl` and `en_in`) and instruction memory (which consumes `pc_out`).

## Interface

Parameters:
- `ADDR_W`, default 16: width of the PC and of every address (minimum 4).
- `OFF_W`, default 8: width of `offset_addr` (must be ≤ `ADDR_W`).
- `STACK_DEPTH`, default 4: number of return-address entries (minimum 1).
- `RESET_ADDR`, default 0: PC value loaded on reset.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `en_in`: input, 1 bit. Update enable. When 0, all state holds.
- `pc_ctrl`: input, 3 bits. Operation select.
- `offset_addr`: input, `OFF_W` bits. Branch offset or short absolute target.
- `jump_addr`: input, `ADDR_W` bits. Long jump or call target.
- `pc_out`: output, `ADDR_W` bits. Current PC (registered).
- `stack_empty`: output, 1 bit. High when the stack holds 0 entries (registered).
- `stack_full`: output, 1 bit. High when the stack holds `STACK_DEPTH` entries (registered).
- `stack_err`: output, 1 bit. One-cycle pulse on an illegal call or return (registered).

## Operation

- Reset (`rst`=0, asynchronous) sets:
  - `pc_out`=`RESET_ADDR`, stack count=0, `stack_empty`=1, `stack_full`=0, `stack_err`=0.
  - Stack RAM contents are not cleared; their values are don't-care.
- With `en_in`=1, `pc_ctrl` selects the operation:
  - `000` HOLD: `pc_out` unchanged.
  - `001` INC: `pc_out` ← `pc_out`+1.
  - `010` BRANCH: `pc_out` ← `pc_out` + sign-extended `offset_addr`.
  - `011` SHORT JUMP: `pc_out` ← zero-extended `offset_addr`. This is the legacy encoding of the old absolute jump.
  - `100` LONG JUMP: `pc_out` ← `jump_addr`.
  - `101` CALL: push `pc_out`+1 onto the stack, then `pc_out` ← `jump_addr`, count+1.
  - `110` RETURN: `pc_out` ← top of stack (pop), count−1.
  - `111` reserved: behaves as HOLD and does not raise an error.
- Arithmetic: all PC arithmetic is modulo 2^`ADDR_W` and wraps silently.
  - INC from all-ones gives 0.
  - BRANCH with offset −1 from 0 gives all-ones.
  - The pushed return address `pc_out`+1 wraps the same way.
- Stack: a LIFO of `STACK_DEPTH` × `ADDR_W` bits, with count in range 0..`STACK_DEPTH`.
  - `stack_empty` = (count==0).
  - `stack_full` = (count==`STACK_DEPTH`).
- CALL when `stack_full`=1:
  - No push; `pc_out` holds; count unchanged.
  - `stack_err`=1 for the next cycle.
- RETURN when `stack_empty`=1:
  - `pc_out` holds; count unchanged.
  - `stack_err`=1 for the next cycle.
- `stack_err` is 0 in every other cycle, including any cycle with `en_in`=0.
- With `en_in`=0: `pc_out`, stack contents, count and flags all hold, and `stack_err` goes to 0. Inputs are ignored.
- Edge case `STACK_DEPTH`=1: a CALL raises `stack_full`, and the following RETURN clears it.

## Timing

- Every operation takes effect on the rising edge where `en_in`=1. The new `pc_out` and flags are visible in the following cycle, so latency is 1 cycle.
- There is no combinational path from any input to any output.
- Back-to-back operations are legal in every cycle:
  - CALL followed immediately by RETURN restores `pc_out` to the caller's PC+1 in 2 cycles.
  - RETURN immediately after CALL reads the entry just written, with no bubble.
- Reset is asserted asynchronously and released synchronously by the system. Reset in the middle of a call sequence discards all stack state: the next RETURN errors.
- The first operation after reset release applies at the first rising edge with `rst`=1 and `en_in`=1.

## Test plan

- Reset and INC, with `ADDR_W`=16 and `RESET_ADDR`=0x0010:
  - Release reset and apply 3× INC, giving `pc_out` 0x0011, 0x0012, 0x0013.
  - Then drive `en_in`=0 for 2 cycles: `pc_out` stays 0x0013.
- Branch and wrap:
  - From `pc_out`=0x0002, BRANCH with offset 0xFC (−4) gives 0xFFFE.
  - Then INC, INC gives 0xFFFF, then 0x0000.
- Jumps:
  - SHORT JUMP with `offset_addr`=0xA5 gives 0x00A5.
  - LONG JUMP with `jump_addr`=0x1234 gives 0x1234.
  - `pc_ctrl`=111 leaves 0x1234 with `stack_err`=0.
- Nested calls, with `STACK_DEPTH`=4:
  - From 0x0100, CALL 0x0200, then CALL 0x0300.
  - RETURN gives 0x0201; RETURN gives 0x0101.
  - `stack_empty` is 1 after the second return.
- Overflow and underflow, with `STACK_DEPTH`=4:
  - 4 CALLs set `stack_full`=1. A 5th CALL leaves `pc_out` unchanged and pulses `stack_err` high for exactly 1 cycle.
  - 4 RETURNs then 1 more: the last RETURN holds `pc_out` and pulses `stack_err`.
- Reset mid-operation:
  - After 2 CALLs, assert `rst`=0 between clock edges: `pc_out` becomes `RESET_ADDR` immediately and `stack_empty`=1.
  - A RETURN after release pulses `stack_err`.
